// File: rtl/imem_loader.sv
// imem_loader
//   Receives a framed byte stream from a host and writes it into the
//   writable instruction memory, holding the core in halt until a frame
//   with a good checksum has been written.
//
//   Frame: LEN (N = 0..255), N data bytes, CHK (XOR of the data bytes).
//   The frame is rejected in LEN if N bytes starting at BASE_ADDR would
//   run past the top of the address space.
//
// Ports
//   clk         system clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   start       begin a load (honoured only in IDLE, DONE or ERR)
//   in_data     stream byte
//   in_valid    in_data is valid
//   in_ready    loader accepts in_data this cycle
//   imem_we     instruction memory write enable (registered)
//   imem_addr   instruction memory write address (registered)
//   imem_wdata  instruction memory write data (registered)
//   core_halt   stalls the core while the image is not trusted
//   load_busy   a frame is being received (LEN, DATA, CHK)
//   load_done   one-cycle pulse after a successful load
//   load_err    sticky error flag, cleared by start or rst
module imem_loader #(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              core_halt,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err
);

  // Number of locations from BASE_ADDR to the top of the address space;
  // a frame longer than this would wrap, so it is refused up front.
  localparam int unsigned CAPACITY = (1 << ADDR_W) - int'(BASE_ADDR);

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  state_t            state;
  logic [7:0]        count;
  logic [7:0]        acc;
  logic [ADDR_W-1:0] ptr;

  // The stream side is ready exactly while a frame is being received, so
  // ready and busy are plain decodes of the registered state.
  assign in_ready  = (state == LEN) || (state == DATA) || (state == CHK);
  assign load_busy = in_ready;

  // NOTE: every register here is assigned with <= so all of them update
  // together from the values sampled at the same clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      acc        <= '0;
      ptr        <= BASE_ADDR;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
      core_halt  <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle and are raised only by
      // the branch that produces the event, giving single-cycle strobes.
      imem_we   <= 1'b0;
      load_done <= 1'b0;

      unique case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state     <= LEN;
            load_err  <= 1'b0;
            acc       <= '0;
            core_halt <= 1'b1;
          end
        end

        LEN: begin
          if (in_valid) begin
            count <= in_data;
            if (32'(in_data) > CAPACITY) begin
              state    <= ERR;
              load_err <= 1'b1;
            end else if (in_data == 8'd0) begin
              state <= CHK;
            end else begin
              state <= DATA;
              ptr   <= BASE_ADDR;
            end
          end
        end

        DATA: begin
          if (in_valid) begin
            imem_we    <= 1'b1;
            imem_addr  <= ptr;
            imem_wdata <= in_data;
            ptr        <= ptr + 1'b1;
            acc        <= acc ^ in_data;
            count      <= count - 8'd1;
            // count still holds the pre-decrement value: 1 means this
            // byte is the last one of the frame.
            if (count == 8'd1) state <= CHK;
          end
        end

        CHK: begin
          if (in_valid) begin
            if (in_data == acc) begin
              state     <= DONE;
              load_done <= 1'b1;
              core_halt <= 1'b0;
            end else begin
              state    <= ERR;
              load_err <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
